// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP48A1 command sequencer.
// Defining DSP_SEQ_CARRYOUT_EN widens each result entry so the slice carry-out is stored with P.
package dsp_seq_pkg;

    localparam int AB_W = 18;
    localparam int C_W  = 48;
    localparam int OP_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

`ifdef DSP_SEQ_CARRYOUT_EN
    localparam int RES_W = C_W + 1;
`else
    localparam int RES_W = C_W;
`endif

endpackage

// File: rtl/dsp_seq_res_fifo.sv
// Synchronous result FIFO with a registered occupancy count and no write-to-read bypass.
// The head data is forced to zero while empty, so stale entries never show on the output.
module dsp_seq_res_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && (r_count != FULL_COUNT);
    assign w_doPop  = i_pop && (r_count != '0);

    // Storage array; contents need no reset because the count decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rdPtr];

endmodule

// File: rtl/dsp_cmd_sequencer.sv
// Feeds a DSP48A1 slice from a valid/ready command stream and captures P into a result FIFO.
// Commands are tagged through the slice's fixed latency; credits keep the FIFO from overflowing.
// Build option DSP_SEQ_CARRYOUT_EN stores DSP_CARRYOUT with each result and adds res_carryout.
module dsp_cmd_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int              LATENCY    = 4,
    parameter int              RES_DEPTH  = 8,
    parameter int              RST_CYCLES = 2,
    parameter logic [OP_W-1:0] BUBBLE_OP  = 8'h00
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [AB_W-1:0]              cmd_a,
    input  logic [AB_W-1:0]              cmd_b,
    input  logic [AB_W-1:0]              cmd_d,
    input  logic [C_W-1:0]               cmd_c,
    input  logic [OP_W-1:0]              cmd_opmode,
    input  logic                         cmd_carryin,
    output logic [AB_W-1:0]              DSP_A,
    output logic [AB_W-1:0]              DSP_B,
    output logic [AB_W-1:0]              DSP_D,
    output logic [C_W-1:0]               DSP_C,
    output logic [OP_W-1:0]              DSP_OPMODE,
    output logic                         DSP_CARRYIN,
    output logic                         DSP_CE,
    output logic                         DSP_RST,
    input  logic [C_W-1:0]               DSP_P,
    input  logic                         DSP_CARRYOUT,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [C_W-1:0]               res_p,
`ifdef DSP_SEQ_CARRYOUT_EN
    output logic                         res_carryout,
`endif
    output logic [$clog2(RES_DEPTH):0]   inflight
);

    localparam int CNT_W = $clog2(RES_DEPTH) + 1;
    localparam int RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]   INIT_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(RES_DEPTH);

    seq_state_t        r_state;
    seq_state_t        w_nextState;
    logic [RCW-1:0]    r_initCnt;
    logic [LATENCY:0]  r_tag;
    logic [CNT_W-1:0]  r_inflight;
    logic [CNT_W-1:0]  w_fifoCount;
    logic [CNT_W:0]    w_used;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [RES_W-1:0]  w_wdata;
    logic [RES_W-1:0]  w_rdata;

    // State register; reset always returns to INIT so the slice reset sequence repeats.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Counts the edges spent in INIT while the slice is held in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_initCnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_initCnt <= r_initCnt + 1'b1;
        end
    end

    // Next-state and slice control: reset held in INIT, clock-enabled every cycle in RUN.
    always_comb begin
        w_nextState = r_state;
        DSP_RST     = 1'b1;
        DSP_CE      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_initCnt == INIT_LAST) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                DSP_RST = 1'b0;
                DSP_CE  = 1'b1;
            end
            default: w_nextState = ST_INIT;
        endcase
    end

    // Credit uses only registered counts, so a pop frees a slot one cycle later.
    assign w_used    = {1'b0, r_inflight} + {1'b0, w_fifoCount};
    assign cmd_ready = (r_state == ST_RUN) && (w_used < CREDIT_MAX);
    assign w_accept  = cmd_valid && cmd_ready;

    // Operand registers: load the accepted command, otherwise drive a bubble.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DSP_A       <= '0;
            DSP_B       <= '0;
            DSP_D       <= '0;
            DSP_C       <= '0;
            DSP_OPMODE  <= '0;
            DSP_CARRYIN <= 1'b0;
        end else if (w_accept) begin
            DSP_A       <= cmd_a;
            DSP_B       <= cmd_b;
            DSP_D       <= cmd_d;
            DSP_C       <= cmd_c;
            DSP_OPMODE  <= cmd_opmode;
            DSP_CARRYIN <= cmd_carryin;
        end else begin
            DSP_A       <= '0;
            DSP_B       <= '0;
            DSP_D       <= '0;
            DSP_C       <= '0;
            DSP_OPMODE  <= BUBBLE_OP;
            DSP_CARRYIN <= 1'b0;
        end
    end

    // Tag pipe tracks which slice slots carry real commands; the last stage marks P to capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tag <= '0;
        end else begin
            r_tag <= {r_tag[LATENCY-1:0], w_accept};
        end
    end

    assign w_push = r_tag[LATENCY];

    // Commands inside the slice: up on accept, down when the tag reaches the FIFO write stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;

`ifdef DSP_SEQ_CARRYOUT_EN
    assign w_wdata      = {DSP_CARRYOUT, DSP_P};
    assign res_carryout = w_rdata[C_W];
`else
    logic w_unusedCarry;
    assign w_unusedCarry = DSP_CARRYOUT;
    assign w_wdata       = DSP_P;
`endif

    assign res_valid = !w_empty;
    assign w_pop     = res_valid && res_ready;
    assign res_p     = w_rdata[C_W-1:0];

    dsp_seq_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (RES_W)
    ) u_resFifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_count (w_fifoCount)
    );

endmodule

// File: tb/tb_dsp_cmd_sequencer.sv
// Bench for dsp_cmd_sequencer with a behavioural 4-stage DSP48A1 slice model.
// Expected results are computed from each accepted command and kept in a queue in command order.
// Compile with DSP_SEQ_CARRYOUT_EN to also check res_carryout.
module tb_dsp_cmd_sequencer;

    localparam int LATENCY    = 4;
    localparam int RES_DEPTH  = 8;
    localparam int RST_CYCLES = 2;
    localparam logic [7:0] BUBBLE_OP = 8'h00;

    logic        CLK;
    logic        RST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [17:0] cmd_a, cmd_b, cmd_d;
    logic [47:0] cmd_c;
    logic [7:0]  cmd_opmode;
    logic        cmd_carryin;
    logic [17:0] DSP_A, DSP_B, DSP_D;
    logic [47:0] DSP_C;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_CARRYIN;
    logic        DSP_CE;
    logic        DSP_RST;
    logic [47:0] DSP_P;
    logic        DSP_CARRYOUT;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_p;
`ifdef DSP_SEQ_CARRYOUT_EN
    logic        res_carryout;
`endif
    logic [3:0]  inflight;

    int errors = 0;
    int checks = 0;
    logic [48:0] expQ [$];
    logic [48:0] slicePipe [LATENCY];

    dsp_cmd_sequencer #(
        .LATENCY    (LATENCY),
        .RES_DEPTH  (RES_DEPTH),
        .RST_CYCLES (RST_CYCLES),
        .BUBBLE_OP  (BUBBLE_OP)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_d        (cmd_d),
        .cmd_c        (cmd_c),
        .cmd_opmode   (cmd_opmode),
        .cmd_carryin  (cmd_carryin),
        .DSP_A        (DSP_A),
        .DSP_B        (DSP_B),
        .DSP_D        (DSP_D),
        .DSP_C        (DSP_C),
        .DSP_OPMODE   (DSP_OPMODE),
        .DSP_CARRYIN  (DSP_CARRYIN),
        .DSP_CE       (DSP_CE),
        .DSP_RST      (DSP_RST),
        .DSP_P        (DSP_P),
        .DSP_CARRYOUT (DSP_CARRYOUT),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_p        (res_p),
`ifdef DSP_SEQ_CARRYOUT_EN
        .res_carryout (res_carryout),
`endif
        .inflight     (inflight)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Simplified slice arithmetic: P = Z + X + CIN, with carry-out in bit 48.
    function automatic logic [48:0] sliceFn(input logic [17:0] a, input logic [17:0] b,
                                            input logic [17:0] d, input logic [47:0] c,
                                            input logic [7:0] op, input logic cin);
        logic [47:0] x;
        logic [47:0] z;
        case (op[1:0])
            2'b01:   x = {30'b0, a} * {30'b0, b};
            2'b11:   x = {d[11:0], a, b};
            default: x = '0;
        endcase
        z = (op[3:2] == 2'b11) ? c : 48'b0;
        return {1'b0, z} + {1'b0, x} + {48'b0, (cin & op[5])};
    endfunction

    // Slice model: samples its pins on each enabled edge, P appears LATENCY edges later.
    always @(posedge CLK) begin
        if (DSP_RST) begin
            for (int i = 0; i < LATENCY; i++) slicePipe[i] <= '0;
        end else if (DSP_CE) begin
            slicePipe[0] <= sliceFn(DSP_A, DSP_B, DSP_D, DSP_C, DSP_OPMODE, DSP_CARRYIN);
            for (int i = 1; i < LATENCY; i++) slicePipe[i] <= slicePipe[i-1];
        end
    end

    assign DSP_P        = slicePipe[LATENCY-1][47:0];
    assign DSP_CARRYOUT = slicePipe[LATENCY-1][48];

    // Reference model: every accepted command adds its expected result; reset discards all.
    always @(negedge CLK) begin
        if (!RST_N) begin
            expQ.delete();
        end else if (cmd_valid && cmd_ready) begin
            expQ.push_back(sliceFn(cmd_a, cmd_b, cmd_d, cmd_c, cmd_opmode, cmd_carryin));
        end
        if (expQ.size() > RES_DEPTH) begin
            errors++;
            $display("[TB] FAIL credit_overflow outstanding=%0d limit=%0d", expQ.size(), RES_DEPTH);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] timeout");
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic setCmd(input logic v, input logic [17:0] a, input logic [17:0] b,
                          input logic [47:0] c, input logic [7:0] op, input logic cin);
        cmd_valid   = v;
        cmd_a       = a;
        cmd_b       = b;
        cmd_d       = '0;
        cmd_c       = c;
        cmd_opmode  = op;
        cmd_carryin = cin;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (DSP_RST !== 1'b1 || DSP_CE !== 1'b0 || cmd_ready !== 1'b0 || res_valid !== 1'b0 ||
                inflight !== 4'd0 || DSP_OPMODE !== 8'h00 || DSP_A !== 18'd0 || res_p !== 48'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs rst=%b ce=%b rdy=%b rv=%b infl=%0d op=%h required rst=1 others 0",
                         DSP_RST, DSP_CE, cmd_ready, res_valid, inflight, DSP_OPMODE);
            end
        end
        RST_N = 1'b1;
        #1;
        for (int e = 0; e <= RST_CYCLES; e++) begin
            checks++;
            if (DSP_RST !== (e < RST_CYCLES) || cmd_ready !== (e >= RST_CYCLES) ||
                DSP_CE !== (e >= RST_CYCLES) || res_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL init_sequence edge=%0d rst=%b rdy=%b ce=%b rv=%b required rst=%b rdy=%b",
                         e, DSP_RST, cmd_ready, DSP_CE, res_valid, (e < RST_CYCLES), (e >= RST_CYCLES));
            end
            cycle();
        end
    endtask

    task automatic test_single();
        setCmd(1'b1, 18'd20, 18'd10, 48'd0, 8'b0000_0001, 1'b0);
        cycle();
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        for (int j = 0; j <= LATENCY + 1; j++) begin
            checks++;
            if (inflight !== ((j <= LATENCY) ? 4'd1 : 4'd0) || res_valid !== (j == LATENCY + 1)) begin
                errors++;
                $display("[TB] FAIL single_timing edge=k+%0d inflight=%0d rv=%b required inflight=%0d rv=%b",
                         j, inflight, res_valid, (j <= LATENCY) ? 1 : 0, (j == LATENCY + 1));
            end
            if (j <= LATENCY) cycle();
        end
        checks++;
        if (res_p !== 48'd200) begin
            errors++;
            $display("[TB] FAIL single_result res_p=%0d required 200", res_p);
        end
        res_ready = 1'b1;
        void'(expQ.pop_front());
        cycle();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain rv=%b required 0", res_valid);
        end
    endtask

    task automatic test_credit_full();
        int accepted = 0;
        logic [48:0] exp;
        res_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            setCmd(accepted < 10, 18'(accepted), 18'd1, 48'd0, 8'h01, 1'b0);
            if (cmd_valid && cmd_ready) accepted++;
            cycle();
        end
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        checks++;
        if (accepted !== RES_DEPTH || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL credit_limit accepted=%0d rdy=%b required %0d and 0", accepted, cmd_ready, RES_DEPTH);
        end
        res_ready = 1'b1;
        for (int i = 0; i < RES_DEPTH; i++) begin
            exp = (expQ.size() > 0) ? expQ.pop_front() : 49'h1_FFFF_FFFF_FFFF;
            checks++;
            if (res_valid !== 1'b1 || res_p !== 48'(i) || res_p !== exp[47:0]) begin
                errors++;
                $display("[TB] FAIL credit_order idx=%0d rv=%b res_p=%0d required %0d", i, res_valid, res_p, i);
            end
            if (i == 0) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL credit_same_cycle rdy=%b required 0", cmd_ready);
                end
            end
            cycle();
            if (i == 0) begin
                checks++;
                if (cmd_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL credit_return rdy=%b required 1", cmd_ready);
                end
            end
        end
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL credit_drain rv=%b required 0", res_valid);
        end
    endtask

    task automatic test_bubble();
        int popped = 0;
        logic [48:0] exp;
        res_ready = 1'b0;
        setCmd(1'b1, 18'd3, 18'd7, 48'd0, 8'h01, 1'b0);
        cycle();
        setCmd(1'b0, 0, 0, 0, 8'h5A, 1'b0);
        checks++;
        if (DSP_A !== 18'd3 || DSP_B !== 18'd7 || DSP_OPMODE !== 8'h01) begin
            errors++;
            $display("[TB] FAIL bubble_issue a=%0d b=%0d op=%h required 3 7 01", DSP_A, DSP_B, DSP_OPMODE);
        end
        for (int g = 0; g < 3; g++) begin
            cycle();
            checks++;
            if (DSP_OPMODE !== BUBBLE_OP || DSP_A !== 18'd0 || DSP_C !== 48'd0 || DSP_CARRYIN !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bubble_gap g=%0d op=%h a=%0d required op=%h a=0", g, DSP_OPMODE, DSP_A, BUBBLE_OP);
            end
            if (g == 2) setCmd(1'b1, 18'd5, 18'd9, 48'd0, 8'h01, 1'b0);
        end
        cycle();
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        for (int w = 0; w < 10; w++) cycle();
        res_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (res_valid) begin
                exp = (expQ.size() > 0) ? expQ.pop_front() : 49'h1_FFFF_FFFF_FFFF;
                checks++;
                if (res_p !== exp[47:0]) begin
                    errors++;
                    $display("[TB] FAIL bubble_result idx=%0d res_p=%0d required %0d", popped, res_p, exp[47:0]);
                end
                popped++;
            end
            cycle();
        end
        res_ready = 1'b0;
        checks++;
        if (popped !== 2) begin
            errors++;
            $display("[TB] FAIL bubble_count entries=%0d required 2", popped);
        end
    endtask

    task automatic test_reset_midway();
        int stale = 0;
        logic [48:0] exp;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setCmd(1'b1, 18'(i + 1), 18'd2, 48'd0, 8'h01, 1'b0);
            cycle();
        end
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        cycle();
        cycle();
        checks++;
        if (res_valid !== 1'b1 || inflight !== 4'd3) begin
            errors++;
            $display("[TB] FAIL midreset_setup rv=%b inflight=%0d required 1 and 3", res_valid, inflight);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || inflight !== 4'd0 || cmd_ready !== 1'b0 || DSP_RST !== 1'b1 || res_p !== 48'd0) begin
            errors++;
            $display("[TB] FAIL midreset_immediate rv=%b inflight=%0d rdy=%b rst=%b required 0 0 0 1",
                     res_valid, inflight, cmd_ready, DSP_RST);
        end
        cycle();
        cycle();
        RST_N = 1'b1;
        res_ready = 1'b1;
        for (int t = 0; t < 14; t++) begin
            if (res_valid) stale++;
            cycle();
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_stale cycles_with_result=%0d required 0", stale);
        end
        setCmd(1'b1, 18'd11, 18'd11, 48'd0, 8'h01, 1'b0);
        cycle();
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        res_ready = 1'b0;
        for (int w = 0; w < LATENCY + 1; w++) cycle();
        exp = (expQ.size() > 0) ? expQ.pop_front() : 49'h1_FFFF_FFFF_FFFF;
        checks++;
        if (res_valid !== 1'b1 || res_p !== 48'd121 || res_p !== exp[47:0]) begin
            errors++;
            $display("[TB] FAIL midreset_fresh rv=%b res_p=%0d required 1 and 121", res_valid, res_p);
        end
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_carry();
        res_ready = 1'b0;
        setCmd(1'b1, 18'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 8'h2C, 1'b1);
        cycle();
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        for (int w = 0; w < LATENCY + 1; w++) cycle();
        void'(expQ.pop_front());
        checks++;
        if (res_valid !== 1'b1 || res_p !== 48'd0) begin
            errors++;
            $display("[TB] FAIL carry_result rv=%b res_p=%h required 1 and 0", res_valid, res_p);
        end
`ifdef DSP_SEQ_CARRYOUT_EN
        checks++;
        if (res_carryout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL carry_out res_carryout=%b required 1", res_carryout);
        end
`endif
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        logic [7:0] ops [6];
        logic [48:0] exp;
        ops[0] = 8'h01; ops[1] = 8'h0D; ops[2] = 8'h2C;
        ops[3] = 8'h2D; ops[4] = 8'h03; ops[5] = 8'h00;
        for (int cyc = 0; cyc < 300; cyc++) begin
            setCmd(1'($urandom_range(0, 1)), 18'($urandom), 18'($urandom),
                   {16'($urandom), 32'($urandom)}, ops[$urandom_range(0, 5)], 1'($urandom));
            cmd_d = 18'($urandom);
            res_ready = ($urandom_range(0, 9) < 6);
            if (res_valid && res_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL random_extra res_p=%h required no result", res_p);
                end else begin
                    exp = expQ.pop_front();
                    if (res_p !== exp[47:0]
`ifdef DSP_SEQ_CARRYOUT_EN
                        || res_carryout !== exp[48]
`endif
                    ) begin
                        errors++;
                        $display("[TB] FAIL random_result cyc=%0d res_p=%h required %h", cyc, res_p, exp[47:0]);
                    end
                end
            end
            cycle();
        end
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        res_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (res_valid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL random_extra res_p=%h required no result", res_p);
                end else begin
                    exp = expQ.pop_front();
                    if (res_p !== exp[47:0]) begin
                        errors++;
                        $display("[TB] FAIL random_drain res_p=%h required %h", res_p, exp[47:0]);
                    end
                end
            end
            cycle();
        end
        res_ready = 1'b0;
        checks++;
        if (expQ.size() != 0 || res_valid !== 1'b0 || inflight !== 4'd0) begin
            errors++;
            $display("[TB] FAIL random_lost outstanding=%0d rv=%b inflight=%0d required 0 0 0",
                     expQ.size(), res_valid, inflight);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        res_ready = 1'b0;
        setCmd(1'b0, 0, 0, 0, 8'h00, 1'b0);
        test_reset();
        test_single();
        test_credit_full();
        test_bubble();
        test_reset_midway();
        test_carry();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
